// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word reads to
// instruction memory and delivers responses in order through a small FIFO.
module instruction_fetch_checker #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CW         = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          resp_valid_i,
    input logic          push_i,
    input logic [CW-1:0] count_i,
    input logic [CW-1:0] outstanding_i
);
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (count_i == FULL_C)));

    a_resp_has_request: assert property (@(posedge clk_i) disable iff (rst_i)
        !(resp_valid_i && (outstanding_i == {CW{1'b0}})));
endmodule

module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_IMemReqValid,
    input  logic        i_IMemReqReady,
    output logic [31:0] o_IMemAddr,
    input  logic        i_IMemRespValid,
    input  logic [31:0] i_IMemRespData,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectTarget,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_InstructionWord,
    output logic [31:0] o_PC,
    output logic        o_FetchFault
);
    localparam int unsigned  AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned  CW      = AW + 1;
    localparam logic [CW:0]  DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]  RESET_PC_C = {RESET_VECTOR[31:2], 2'b00};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   word_mem_q  [FIFO_DEPTH];
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic          fault_mem_q [FIFO_DEPTH];

    logic          pop_s, accept_s, resp_push_s, resp_drop_s;
    logic          wr_en_s, wr_fault_s;
    logic [AW-1:0] wr_idx_s;
    logic [31:0]   wr_word_s, wr_pc_s;
    logic [CW:0]   credit_s;

    assign o_Valid           = (count_q != {CW{1'b0}});
    assign pop_s             = o_Valid && i_Ready;
    assign o_InstructionWord = o_Valid ? word_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign o_PC              = o_Valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign o_FetchFault      = o_Valid && fault_mem_q[rd_ptr_q];

    // Credits count both buffered entries and requests whose words are still in flight.
    assign credit_s       = {1'b0, count_q} + {1'b0, outst_q} - {{CW{1'b0}}, pop_s};
    assign o_IMemReqValid = (state_q == ST_RUN) && (credit_s < DEPTH_C) && !i_Reset;
    assign o_IMemAddr     = fetch_pc_q;
    assign accept_s       = o_IMemReqValid && i_IMemReqReady;
    assign resp_drop_s    = i_IMemRespValid && (discard_q != {CW{1'b0}});
    assign resp_push_s    = i_IMemRespValid && (discard_q == {CW{1'b0}}) && !i_Redirect;

    // Next-state for PC, counters, FIFO pointers and the single FIFO write port.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = accept_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
        outst_d    = outst_q + CW'(accept_s) - CW'(i_IMemRespValid);
        discard_d  = discard_q - CW'(resp_drop_s);
        resp_pc_d  = resp_push_s ? (resp_pc_q + 32'd4) : resp_pc_q;
        count_d    = count_q + CW'(resp_push_s) - CW'(pop_s);
        rd_ptr_d   = rd_ptr_q + AW'(pop_s);
        wr_ptr_d   = wr_ptr_q + AW'(resp_push_s);
        wr_en_s    = resp_push_s;
        wr_idx_s   = wr_ptr_q;
        wr_word_s  = i_IMemRespData;
        wr_pc_s    = resp_pc_q;
        wr_fault_s = 1'b0;
        if (i_Redirect) begin
            // Everything still in flight after this cycle becomes stale.
            discard_d  = outst_d;
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            fetch_pc_d = {i_RedirectTarget[31:2], 2'b00};
            resp_pc_d  = {i_RedirectTarget[31:2], 2'b00};
            if (i_RedirectTarget[1:0] != 2'b00) begin
                state_d    = ST_FAULT;
                wr_en_s    = 1'b1;
                wr_idx_s   = {AW{1'b0}};
                wr_word_s  = 32'h0000_0000;
                wr_pc_s    = i_RedirectTarget;
                wr_fault_s = 1'b1;
                count_d    = CW'(1);
                wr_ptr_d   = AW'(1);
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC_C;
            resp_pc_q  <= RESET_PC_C;
            count_q    <= {CW{1'b0}};
            outst_q    <= {CW{1'b0}};
            discard_q  <= {CW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage is pure data path; validity lives in count_q.
    always_ff @(posedge i_Clock) begin
        if (wr_en_s) begin
            word_mem_q[wr_idx_s]  <= wr_word_s;
            pc_mem_q[wr_idx_s]    <= wr_pc_s;
            fault_mem_q[wr_idx_s] <= wr_fault_s;
        end
    end

    instruction_fetch_checker #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_checker (
        .clk_i         (i_Clock),
        .rst_i         (i_Reset),
        .resp_valid_i  (i_IMemRespValid),
        .push_i        (resp_push_s),
        .count_i       (count_q),
        .outstanding_i (outst_q)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable in-order memory model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        o_IMemReqValid;
    logic        i_IMemReqReady = 1'b1;
    logic [31:0] o_IMemAddr;
    logic        i_IMemRespValid = 1'b0;
    logic [31:0] i_IMemRespData = 32'h0;
    logic        i_Redirect = 1'b0;
    logic [31:0] i_RedirectTarget = 32'h0;
    logic        o_Valid;
    logic        i_Ready = 1'b1;
    logic [31:0] o_InstructionWord;
    logic [31:0] o_PC;
    logic        o_FetchFault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    int r0;
    int bcyc;

    logic [31:0] maddr_q[$];
    int          mdue_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    logic [31:0] pop_fault[$];
    logic [31:0] pop_cyc[$];

    instruction_fetch #(
        .RESET_VECTOR (32'h0000_0100),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_Clock           (clk),
        .i_Reset           (i_Reset),
        .o_IMemReqValid    (o_IMemReqValid),
        .i_IMemReqReady    (i_IMemReqReady),
        .o_IMemAddr        (o_IMemAddr),
        .i_IMemRespValid   (i_IMemRespValid),
        .i_IMemRespData    (i_IMemRespData),
        .i_Redirect        (i_Redirect),
        .i_RedirectTarget  (i_RedirectTarget),
        .o_Valid           (o_Valid),
        .i_Ready           (i_Ready),
        .o_InstructionWord (o_InstructionWord),
        .o_PC              (o_PC),
        .o_FetchFault      (o_FetchFault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_word.delete();
        pop_fault.delete();
        pop_cyc.delete();
    endtask

    // Memory model and transaction monitor, sampled on the active edge.
    always @(posedge clk) begin
        if (i_Reset) begin
            maddr_q.delete();
            mdue_q.delete();
        end else begin
            if (i_IMemRespValid && maddr_q.size() > 0) begin
                void'(maddr_q.pop_front());
                void'(mdue_q.pop_front());
            end
            if (o_IMemReqValid && i_IMemReqReady) begin
                maddr_q.push_back(o_IMemAddr);
                mdue_q.push_back(cyc + lat);
                req_log.push_back(o_IMemAddr);
            end
            if (o_Valid && i_Ready) begin
                pop_pc.push_back(o_PC);
                pop_word.push_back(o_InstructionWord);
                pop_fault.push_back({31'h0, o_FetchFault});
                pop_cyc.push_back(32'(cyc));
            end
        end
        cyc = cyc + 1;
    end

    // Memory response drive, half a cycle away from the sampling edge.
    always @(negedge clk) begin
        if (maddr_q.size() > 0 && mdue_q[0] <= cyc) begin
            i_IMemRespValid = 1'b1;
            i_IMemRespData  = word_of(maddr_q[0]);
        end else begin
            i_IMemRespValid = 1'b0;
            i_IMemRespData  = 32'h0;
        end
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_valid", {31'h0, o_Valid}, 32'h0);
        check("rst_reqvalid", {31'h0, o_IMemReqValid}, 32'h0);
        check("rst_pc", o_PC, 32'h0);
        check("rst_word", o_InstructionWord, 32'h0);
        check("rst_fault", {31'h0, o_FetchFault}, 32'h0);

        // Streaming from the reset vector
        i_Reset = 1'b0;
        clear_logs();
        r0 = cyc;
        #1;
        check("first_reqvalid", {31'h0, o_IMemReqValid}, 32'h1);
        check("first_addr", o_IMemAddr, 32'h0000_0100);
        repeat (8) step();
        check("s_pop0_pc", at(pop_pc, 0), 32'h0000_0100);
        check("s_pop0_word", at(pop_word, 0), 32'hDEAD_0100);
        check("s_pop0_cyc", at(pop_cyc, 0), 32'(r0 + 2));
        check("s_pop1_pc", at(pop_pc, 1), 32'h0000_0104);
        check("s_pop1_cyc", at(pop_cyc, 1), 32'(r0 + 3));
        check("s_req2", at(req_log, 2), 32'h0000_0108);
        check("s_pop_count", 32'(pop_pc.size()), 32'd6);

        // Backpressure fills the FIFO, then drains in order
        i_Ready = 1'b0;
        repeat (6) step();
        check("bp_valid", {31'h0, o_Valid}, 32'h1);
        check("bp_head_pc", o_PC, 32'h0000_0118);
        check("bp_head_word", o_InstructionWord, 32'hDEAD_0118);
        check("bp_reqvalid", {31'h0, o_IMemReqValid}, 32'h0);
        check("bp_last_req", req_log[$], 32'h0000_0124);
        repeat (3) step();
        check("bp_hold_pc", o_PC, 32'h0000_0118);
        clear_logs();
        i_Ready = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 6; i++) begin
            check("drain_pc", at(pop_pc, i), 32'h0000_0118 + 32'(4 * i));
        end
        check("drain_word3", at(pop_word, 3), 32'hDEAD_0124);

        // Slow memory: two stale responses dropped after redirect
        i_IMemReqReady = 1'b0;
        repeat (8) step();
        lat = 3;
        i_IMemReqReady = 1'b1;
        step();
        step();
        i_IMemReqReady   = 1'b0;
        i_Redirect       = 1'b1;
        i_RedirectTarget = 32'h0000_0200;
        step();
        i_Redirect     = 1'b0;
        i_IMemReqReady = 1'b1;
        clear_logs();
        #1;
        check("rd_valid0", {31'h0, o_Valid}, 32'h0);
        check("rd_reqvalid", {31'h0, o_IMemReqValid}, 32'h1);
        check("rd_addr", o_IMemAddr, 32'h0000_0200);
        repeat (12) step();
        check("rd_pop0_pc", at(pop_pc, 0), 32'h0000_0200);
        check("rd_pop0_word", at(pop_word, 0), 32'hDEAD_0200);
        check("rd_pop1_pc", at(pop_pc, 1), 32'h0000_0204);

        // Redirect coinciding with a response and a pop
        lat = 1;
        repeat (10) step();
        bcyc             = cyc;
        i_Redirect       = 1'b1;
        i_RedirectTarget = 32'h0000_0280;
        step();
        i_Redirect = 1'b0;
        check("rp_popped_cyc", pop_cyc[$], 32'(bcyc));
        check("rp_valid0", {31'h0, o_Valid}, 32'h0);
        clear_logs();
        repeat (6) step();
        check("rp_pop0_pc", at(pop_pc, 0), 32'h0000_0280);

        // Misaligned target produces one fault entry and stops fetch
        i_Redirect       = 1'b1;
        i_RedirectTarget = 32'h0000_0202;
        step();
        i_Redirect = 1'b0;
        clear_logs();
        check("f_valid", {31'h0, o_Valid}, 32'h1);
        check("f_fault", {31'h0, o_FetchFault}, 32'h1);
        check("f_pc", o_PC, 32'h0000_0202);
        check("f_word", o_InstructionWord, 32'h0);
        check("f_reqvalid", {31'h0, o_IMemReqValid}, 32'h0);
        repeat (6) step();
        check("f_no_reqs", 32'(req_log.size()), 32'd0);
        check("f_one_pop", 32'(pop_pc.size()), 32'd1);
        check("f_valid_after", {31'h0, o_Valid}, 32'h0);
        i_Redirect       = 1'b1;
        i_RedirectTarget = 32'h0000_0300;
        step();
        i_Redirect = 1'b0;
        clear_logs();
        check("f_resume_addr", o_IMemAddr, 32'h0000_0300);
        check("f_resume_reqvalid", {31'h0, o_IMemReqValid}, 32'h1);
        repeat (8) step();
        check("f_resume_pc", at(pop_pc, 0), 32'h0000_0300);
        check("f_resume_fault", at(pop_fault, 0), 32'h0);

        // PC wraps past the top of the address space
        i_Redirect       = 1'b1;
        i_RedirectTarget = 32'hFFFF_FFF8;
        step();
        i_Redirect = 1'b0;
        clear_logs();
        repeat (8) step();
        check("w_req0", at(req_log, 0), 32'hFFFF_FFF8);
        check("w_req1", at(req_log, 1), 32'hFFFF_FFFC);
        check("w_req2", at(req_log, 2), 32'h0000_0000);
        check("w_pop2_pc", at(pop_pc, 2), 32'h0000_0000);
        check("w_pop2_word", at(pop_word, 2), 32'hDEAD_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
